// File: rtl/alu_mc_pkg.sv
// Shared constants and state encoding for the multi-cycle ALU responder.
package alu_mc_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OPRN_WIDTH = 6;

    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_MUL = 3;
    localparam int OP_SHR = 4;
    localparam int OP_SHL = 5;
    localparam int OP_AND = 6;
    localparam int OP_OR  = 7;
    localparam int OP_NOR = 8;
    localparam int OP_SLT = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SHIFT,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Shift-add multiplier datapath: one multiplier bit per cycle after start.
module alu_mc_mul #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] rem_q, rem_d;

    // product already includes the iteration in progress this cycle
    assign product = acc_q + (b_q[0] ? a_q : '0);
    assign busy    = (rem_q != '0);

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        rem_d = rem_q;
        if (start) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            rem_d = CW'(W);
        end else if (busy) begin
            acc_d = product;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            rem_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU responder: valid/ready request in, valid/ready result out.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [OPRN_WIDTH-1:0] oprn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  left_q, left_d;

    logic                  mul_start;
    logic                  mul_busy;
    logic [DATA_WIDTH-1:0] mul_product;
    logic                  sh_trivial;

    alu_mc_mul #(.W(DATA_WIDTH)) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .product (mul_product)
    );

    assign sh_trivial = (op2 == '0) ||
                        (op2 >= DATA_WIDTH'(DATA_WIDTH));

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        left_d    = left_q;
        mul_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    case (oprn)
                        OPRN_WIDTH'(OP_ADD): result_d = op1 + op2;
                        OPRN_WIDTH'(OP_SUB): result_d = op1 - op2;
                        OPRN_WIDTH'(OP_AND): result_d = op1 & op2;
                        OPRN_WIDTH'(OP_OR):  result_d = op1 | op2;
                        OPRN_WIDTH'(OP_NOR): result_d = ~(op1 | op2);
                        OPRN_WIDTH'(OP_SLT): result_d = DATA_WIDTH'(op1 < op2);
                        OPRN_WIDTH'(OP_MUL): begin
                            mul_start = 1'b1;
                            cnt_d     = CW'(DATA_WIDTH - 1);
                            state_d   = S_MUL;
                        end
                        OPRN_WIDTH'(OP_SHR),
                        OPRN_WIDTH'(OP_SHL): begin
                            if (sh_trivial) begin
                                result_d = (op2 == '0) ? op1 : '0;
                            end else begin
                                acc_d   = op1;
                                left_d  = (oprn == OPRN_WIDTH'(OP_SHL));
                                cnt_d   = CW'(op2 - 1'b1);
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0 || !mul_busy) begin
                    result_d = mul_product;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                acc_d = left_q ? (acc_q << 1) : (acc_q >> 1);
                if (cnt_q == '0) begin
                    result_d = acc_d;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            left_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            left_q      <= left_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule
